// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI target bridge.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        RDUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    localparam int          CMD_READ_BIT  = 7;
    localparam logic [7:0]  CMD_RSVD_MASK = 8'h7F;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises SCLK/CS/MOSI into the system clock domain and derives SCLK
// rise/fall and CS fall pulses. Generic enough for any SPI target block.
module spi_edge_sync #(
    parameter int SyncStages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_n,
    output logic o_cs_fall,
    output logic o_mosi
);

    if (SyncStages < 2 || SyncStages > 3) begin : g_bad_sync
        $error("spi_edge_sync: SyncStages must be 2 or 3");
    end

    logic [SyncStages-1:0] r_sclk_sync;
    logic [SyncStages-1:0] r_cs_sync;
    logic [SyncStages-1:0] r_mosi_sync;
    logic                  r_sclk_d;
    logic                  r_cs_d;

    // CS resets to "selected" so a reset released mid-frame cannot fake a
    // CS fall; the next frame only starts after a real high-to-low edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SyncStages-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SyncStages-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SyncStages-2:0], i_mosi};
            r_sclk_d    <= r_sclk_sync[SyncStages-1];
            r_cs_d      <= r_cs_sync[SyncStages-1];
        end
    end

    assign o_sclk_rise = r_sclk_sync[SyncStages-1] & ~r_sclk_d;
    assign o_sclk_fall = ~r_sclk_sync[SyncStages-1] & r_sclk_d;
    assign o_cs_n      = r_cs_sync[SyncStages-1];
    assign o_cs_fall   = ~r_cs_sync[SyncStages-1] & r_cs_d;
    assign o_mosi      = r_mosi_sync[SyncStages-1];

endmodule

// File: rtl/spi_target_bridge.sv
// SPI mode-0 target that lets an external host read/write the CPU bus.
// Define SPI_BRIDGE_AUTOINC_EN for burst addressing; otherwise the address is fixed per frame.
module spi_target_bridge
    import spi_bridge_pkg::*;
#(
    parameter int address_width = 16,
    parameter int data_width    = 8,
    parameter int SyncStages    = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     spi_sclk_i,
    input  logic                     spi_cs_ni,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic                     spi_miso_oe_o,
    output logic [address_width-1:0] bus_addr_o,
    output logic [data_width-1:0]    bus_data_o,
    output logic                     bus_we_o,
    output logic                     bus_rd_o,
    input  logic [data_width-1:0]    bus_data_i,
    output logic                     busy_o,
    output logic                     frame_err_o
);

    if (data_width != 8) begin : g_bad_dw
        $error("spi_target_bridge: only data_width == 8 is supported");
    end

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [address_width-1:0] ADDR_ONE = {{(address_width-1){1'b0}}, 1'b1};

    logic w_rise, w_fall, w_cs_n, w_cs_fall, w_mosi, w_oe;
    logic [7:0] w_byte;

    state_t                    r_state;
    logic [2:0]                r_bit_cnt;
    logic [7:0]                r_rx;
    logic [7:0]                r_tx;
    logic [7:0]                r_tx_hold;
    logic [7:0]                r_addr_hi;
    logic [address_width-1:0]  r_addr;
    logic [data_width-1:0]     r_bus_data;
    logic                      r_is_read;
    logic                      r_bus_we;
    logic                      r_bus_rd;
    logic                      r_rd_d;
    logic                      r_frame_err;

    spi_edge_sync #(.SyncStages(SyncStages)) u_sync (
        .i_clk       (clk_i),
        .i_rst_n     (reset_ni),
        .i_sclk      (spi_sclk_i),
        .i_cs_n      (spi_cs_ni),
        .i_mosi      (spi_mosi_i),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall),
        .o_cs_n      (w_cs_n),
        .o_cs_fall   (w_cs_fall),
        .o_mosi      (w_mosi)
    );

    assign w_byte = {r_rx[6:0], w_mosi};
    assign w_oe   = ~w_cs_n & (r_state != IDLE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_tx_hold   <= '0;
            r_addr_hi   <= '0;
            r_addr      <= '0;
            r_bus_data  <= '0;
            r_is_read   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_rd    <= 1'b0;
            r_rd_d      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_bus_we    <= 1'b0;
            r_bus_rd    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_d      <= r_bus_rd;
            if (r_rd_d)
                r_tx_hold <= bus_data_i;
            // Write address advances the cycle after the strobe so the strobe sees the old address.
            if (r_bus_we && AUTOINC)
                r_addr <= r_addr + ADDR_ONE;

            if (r_state == IDLE) begin
                if (w_cs_fall) begin
                    r_state   <= CMD;
                    r_bit_cnt <= '0;
                    r_rx      <= '0;
                    r_tx      <= '0;
                end
            end else begin
                // A rise is honoured even if CS rose in the same cycle, so an
                // 8th rise coincident with deselect still completes its byte.
                if (w_rise) begin
                    r_rx      <= w_byte;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_state)
                            CMD: begin
                                if ((w_byte & CMD_RSVD_MASK) != 8'h00) begin
                                    r_frame_err <= 1'b1;
                                    r_state     <= IGNORE;
                                end else begin
                                    r_is_read <= w_byte[CMD_READ_BIT];
                                    r_state   <= ADDR_HI;
                                end
                            end
                            ADDR_HI: begin
                                r_addr_hi <= w_byte;
                                r_state   <= ADDR_LO;
                            end
                            ADDR_LO: begin
                                r_addr <= address_width'({r_addr_hi, w_byte});
                                if (r_is_read) begin
                                    r_bus_rd <= 1'b1;
                                    r_state  <= RDUMMY;
                                end else begin
                                    r_state  <= WDATA;
                                end
                            end
                            RDUMMY: r_state <= RDATA;
                            WDATA: begin
                                r_bus_we   <= 1'b1;
                                r_bus_data <= w_byte;
                            end
                            default: ;
                        endcase
                    end
                end else if (w_cs_n) begin
                    if (r_bit_cnt != 3'd0)
                        r_frame_err <= 1'b1;
                    r_state <= IDLE;
                end

                // Falls after deselect are dropped: no point preparing MISO or prefetching.
                if (w_fall && !w_cs_n) begin
                    if (r_bit_cnt == 3'd0) begin
                        if (r_state == RDATA) begin
                            r_tx     <= r_tx_hold;
                            r_bus_rd <= 1'b1;
                            if (AUTOINC)
                                r_addr <= r_addr + ADDR_ONE;
                        end else begin
                            r_tx <= 8'h00;
                        end
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso_o    = r_tx[7] & w_oe;
    assign spi_miso_oe_o = w_oe;
    assign bus_addr_o    = r_addr;
    assign bus_data_o    = r_bus_data;
    assign bus_we_o      = r_bus_we;
    assign bus_rd_o      = r_bus_rd;
    assign busy_o        = (r_state != IDLE);
    assign frame_err_o   = r_frame_err;

endmodule
